cdc_pulse_scheduler: RTL and testbench

- Fast-domain controller that shares one fast-to-slow CDC handshake channel between N_REQ pulse requesters.
- Counts single-cycle event pulses per requester, so no event is lost while the channel is busy.
- Grants requesters round-robin and drives a 4-phase req/ack handshake with a bundled requester ID.
- The ack input arrives already synchronised into clk by the existing 2-FF synchroniser.

---
 rtl/cdc_sched_pkg.sv | 7 +
 rtl/cdc_pulse_scheduler_rr_pick.sv | 20 ++
 rtl/cdc_pulse_scheduler.sv | 130 +++++++++++++
 tb/tb_cdc_pulse_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_sched_pkg.sv
// cdc_sched_pkg: shared state encoding and ID-width helper for the CDC pulse scheduler
package cdc_sched_pkg;
  typedef enum logic [1:0] {IDLE, REQ, REL, GAP} state_e;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cdc_pulse_scheduler_rr_pick.sv
// rr_pick: combinational round-robin finder of the first set bit at or after ptr_i, with wrap
module rr_pick
  import cdc_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        nz_i,
  input  logic [id_w(N_REQ)-1:0]  ptr_i,
  output logic                    valid_o,
  output logic [id_w(N_REQ)-1:0]  idx_o
);
  localparam int IW = id_w(N_REQ);
  assign valid_o = |nz_i;
  // scan from the farthest offset down so the nearest hit to ptr_i wins
  always_comb begin
    idx_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (nz_i[(int'(ptr_i) + k) % N_REQ]) idx_o = IW'((int'(ptr_i) + k) % N_REQ);
  end
endmodule

// File: rtl/cdc_pulse_scheduler.sv
// cdc_pulse_scheduler: round-robin sharing of one 4-phase fast-to-slow handshake among N_REQ pulse sources (optional watchdog: CDC_SCHED_TIMEOUT_EN)
module cdc_pulse_scheduler
  import cdc_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CNT_W       = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_pulse,
  input  logic                   sync_ack,
  output logic                   sync_req,
  output logic [id_w(N_REQ)-1:0] sync_id,
  output logic                   busy,
  output logic [N_REQ-1:0]       ovf,
  output logic                   timeout_err
);
  localparam int IW = id_w(N_REQ);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam state_e AFTER = (GAP_CYC == 0) ? IDLE : GAP;

  if (N_REQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("cdc_pulse_scheduler: N_REQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [N_REQ-1:0] ovf_q;
  logic [N_REQ-1:0] nz;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    sync_id_q;
  logic [IW-1:0]    pick_idx;
  logic [GW-1:0]    gap_q;
  logic             sync_req_q;
  logic             pick_v;
  logic             wd_hit;

  for (genvar g = 0; g < N_REQ; g++) begin : g_nz
    assign nz[g] = |cnt_q[g];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .nz_i   (nz),
    .ptr_i  (rr_ptr_q),
    .valid_o(pick_v),
    .idx_o  (pick_idx)
  );

  assign grant       = (state_q == IDLE && pick_v) ? {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx : '0;
  assign sync_req    = sync_req_q;
  assign sync_id     = sync_id_q;
  assign busy        = state_q != IDLE;
  assign ovf         = ovf_q;

  // pending-event counters: pulse adds, grant removes, saturate and flag overflow at all-ones
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (req_pulse[i] && !grant[i]) begin
          if (&cnt_q[i]) ovf_q[i] <= 1'b1;
          else cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (grant[i] && !req_pulse[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
    end

`ifdef CDC_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd_q;
  logic          err_q;
  logic          in_hs;
  logic          hs_move;
  assign in_hs       = state_q == REQ || state_q == REL;
  assign wd_hit      = in_hs && (32'(wd_q) == TIMEOUT_CYC - 1);
  assign hs_move     = (state_q == REQ && sync_ack) || (state_q == REL && !sync_ack) || wd_hit;
  assign timeout_err = err_q;
  // watchdog: counts cycles spent in one handshake state, restarts on every state change
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (in_hs && !hs_move) ? wd_q + 1'b1 : '0;
      if (wd_hit) err_q <= 1'b1;
    end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // handshake FSM: grant in IDLE, raise req, wait ack, drop req, wait ack release, idle gap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      sync_req_q <= 1'b0;
      sync_id_q  <= '0;
      gap_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_v) begin
          state_q    <= REQ;
          sync_req_q <= 1'b1;
          sync_id_q  <= pick_idx;
          rr_ptr_q   <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
        end
        REQ: if (wd_hit) begin
          state_q    <= AFTER;
          sync_req_q <= 1'b0;
          gap_q      <= '0;
        end else if (sync_ack) begin
          state_q    <= REL;
          sync_req_q <= 1'b0;
        end
        REL: if (wd_hit || !sync_ack) begin
          state_q <= AFTER;
          gap_q   <= '0;
        end
        GAP: begin
          gap_q <= gap_q + 1'b1;
          if (32'(gap_q) == GAP_CYC - 1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// tb_cdc_pulse_scheduler: randomized and directed bench against a behavioural scheduler model
module tb_cdc_pulse_scheduler;
`ifdef CDC_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_pulse;
  logic       sync_ack;
  logic       sync_req;
  logic [1:0] sync_id;
  logic       busy;
  logic [3:0] ovf;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  int         m_cnt[4];
  logic [3:0] m_ovf;
  int         m_ptr, m_id, m_gap, m_wd;
  bit         m_req, m_rel, m_err, prev_req;
  int         obs[$];

  always #5 clk = ~clk;

  cdc_pulse_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_pulse  (req_pulse),
    .sync_ack   (sync_ack),
    .sync_req   (sync_req),
    .sync_id    (sync_id),
    .busy       (busy),
    .ovf        (ovf),
    .timeout_err(timeout_err)
  );

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ovf = '0; m_ptr = 0; m_id = 0; m_gap = 0; m_wd = 0;
    m_req = 0; m_rel = 0; m_err = 0; prev_req = 0;
  endfunction

  function automatic bit model_idle();
    return !m_req && !m_rel && m_gap == 0;
  endfunction

  function automatic bit model_empty();
    return model_idle() && m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0 && m_cnt[3] == 0;
  endfunction

  task automatic step(input logic [3:0] p, input logic a);
    int g;
    req_pulse = p;
    sync_ack  = a;
    @(negedge clk);
    g = -1;
    if (model_idle())
      for (int k = 0; k < 4; k++)
        if (g < 0 && m_cnt[(m_ptr + k) % 4] != 0) g = (m_ptr + k) % 4;
    for (int i = 0; i < 4; i++)
      if (p[i] && g != i) begin
        if (m_cnt[i] == 15) m_ovf[i] = 1'b1;
        else m_cnt[i]++;
      end else if (!p[i] && g == i) m_cnt[i]--;
    if (g >= 0) begin
      m_req = 1; m_id = g; m_ptr = (g + 1) % 4; m_wd = 0;
    end else if ((m_req || m_rel) && TO_EN && m_wd == 63) begin
      m_req = 0; m_rel = 0; m_gap = GAP; m_err = 1; m_wd = 0;
    end else if (m_req && a) begin
      m_req = 0; m_rel = 1; m_wd = 0;
    end else if (m_rel && !a) begin
      m_rel = 0; m_gap = GAP; m_wd = 0;
    end else if (m_req || m_rel) m_wd++;
    else if (m_gap > 0) m_gap--;
    checks++;
    if (sync_req !== m_req) begin
      errors++; $display("FAIL model sync_req: got %b expected %b at %0t", sync_req, m_req, $time);
    end
    checks++;
    if (busy !== !model_idle()) begin
      errors++; $display("FAIL model busy: got %b expected %b at %0t", busy, !model_idle(), $time);
    end
    checks++;
    if (ovf !== m_ovf) begin
      errors++; $display("FAIL model ovf: got %b expected %b at %0t", ovf, m_ovf, $time);
    end
    checks++;
    if (timeout_err !== m_err) begin
      errors++; $display("FAIL model timeout_err: got %b expected %b at %0t", timeout_err, m_err, $time);
    end
    if (m_req) begin
      checks++;
      if (sync_id !== m_id[1:0]) begin
        errors++; $display("FAIL model sync_id: got %0d expected %0d at %0t", sync_id, m_id, $time);
      end
    end
    if (sync_req && !prev_req) obs.push_back(int'(sync_id));
    prev_req = sync_req;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_pulse = '0; sync_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (!model_empty() && n < 3000) begin
      step(4'b0000, sync_req);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++; $display("FAIL drain timeout: got %0d cycles expected < 3000", n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({sync_req, sync_id, busy, ovf, timeout_err} !== 9'b0) begin
      errors++; $display("FAIL reset outputs: got %b expected 0", {sync_req, sync_id, busy, ovf, timeout_err});
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0 || dut.cnt_q[0] !== 4'd0 || dut.cnt_q[3] !== 4'd0) begin
      errors++; $display("FAIL reset state: got ptr %0d cnt0 %0d expected 0", dut.rr_ptr_q, dut.cnt_q[0]);
    end
  endtask

  task automatic test_single();
    step(4'b0010, 1'b0);
    checks++;
    if (sync_req !== 1'b0) begin
      errors++; $display("FAIL single early_req: got %b expected 0", sync_req);
    end
    step(4'b0000, 1'b0);
    checks++;
    if (sync_req !== 1'b1 || sync_id !== 2'd1) begin
      errors++; $display("FAIL single latency: got req %b id %0d expected req 1 id 1", sync_req, sync_id);
    end
    repeat (2) step(4'b0000, 1'b0);
    repeat (3) step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL single gap_busy: got %b expected 1", busy);
    end
    step(4'b0000, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single idle: got %b expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    step(4'b1111, 1'b0);
    drain();
    checks++;
    if (obs.size() != 4 || obs[0] != 0 || obs[1] != 1 || obs[2] != 2 || obs[3] != 3) begin
      errors++; $display("FAIL rr order1: got %p expected '{0,1,2,3}", obs);
    end
    obs.delete();
    step(4'b1001, 1'b0);
    drain();
    checks++;
    if (obs.size() != 2 || obs[0] != 0 || obs[1] != 3) begin
      errors++; $display("FAIL rr order2: got %p expected '{0,3}", obs);
    end
  endtask

  task automatic test_backlog();
    apply_reset();
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    obs.delete();
    repeat (5) step(4'b0100, 1'b0);
    drain();
    checks++;
    if (obs.size() != 5 || obs.sum() != 10) begin
      errors++; $display("FAIL backlog count: got %0d handshakes ids %p expected 5 of id 2", obs.size(), obs);
    end
    checks++;
    if (ovf !== 4'b0000) begin
      errors++; $display("FAIL backlog ovf: got %b expected 0000", ovf);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    repeat (17) step(4'b0001, 1'b0);
    checks++;
    if (ovf !== 4'b0001 || dut.cnt_q[0] !== 4'd15) begin
      errors++; $display("FAIL overflow: got ovf %b cnt %0d expected ovf 0001 cnt 15", ovf, dut.cnt_q[0]);
    end
    drain();
    checks++;
    if (ovf !== 4'b0001) begin
      errors++; $display("FAIL overflow sticky: got %b expected 0001", ovf);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    checks++;
    if (dut.cnt_q[1] !== 4'd1 || sync_req !== 1'b1) begin
      errors++; $display("FAIL simul cnt: got cnt %0d req %b expected cnt 1 req 1", dut.cnt_q[1], sync_req);
    end
    drain();
    checks++;
    if (obs.size() != 2 || obs[0] != 1 || obs[1] != 1) begin
      errors++; $display("FAIL simul handshakes: got %p expected '{1,1}", obs);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(4'b0100, 1'b0);
    step(4'b1011, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sync_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got req %b busy %b expected 0 0", sync_req, busy);
    end
    checks++;
    if (dut.cnt_q[0] !== 4'd0 || dut.cnt_q[1] !== 4'd0 || dut.cnt_q[3] !== 4'd0) begin
      errors++; $display("FAIL async_reset cnt: got %0d %0d %0d expected 0", dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[3]);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) step(4'b0000, 1'b0);
  endtask

`ifdef CDC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    apply_reset();
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    while (sync_req && hi < 200) begin
      hi++;
      step(4'b0000, 1'b0);
    end
    checks++;
    if (hi != 64 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout: got %0d req cycles err %b expected 64 and 1", hi, timeout_err);
    end
    drain();
  endtask
`endif

  task automatic test_random();
    logic a = 1'b0;
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      if (sync_req != a && $urandom_range(0, 2) == 0) a = sync_req;
      step(4'($urandom) & 4'($urandom) & 4'($urandom), a);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; req_pulse = '0; sync_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backlog();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
`ifdef CDC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
